serial_adder: RTL and testbench

- Bit-serial N-bit adder built around one instance of the team's existing 1-bit full_adder cell, plus a carry flip-flop.
- Accepts two WIDTH-bit operands and a carry-in on a start pulse, then adds one bit per clock, LSB first.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done strobe.
- Area-cheap adder stage feeding downstream accumulate/compare logic.

---
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry flop, LSB first.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow output (ovf).

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sr, b_sr, sum_q;
    logic [CW-1:0]    cnt;
    logic             carry_q, cout_q;
    logic             fa_s, fa_c;
    logic             load, step, last;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // DONE accepts a new start directly so back-to-back operations skip IDLE.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (load) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
        end else if (step) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
            carry_q <= fa_c;
            cnt     <= cnt + CW'(1);
            if (last) cout_q <= fa_c;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the last step carry_q is the carry into the MSB and fa_c the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            ovf_q <= 1'b0;
        else if (step && last) ovf_q <= carry_q ^ fa_c;
    end

    assign ovf = ovf_q;
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); also covers ovf when
// SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int tests = 0;
    int fails = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents operands for exactly the accepting edge; returns 1 ns after it.
    task automatic pulse_start(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        a = va; b = vb; cin = vc; start = 1'b1;
        step_cycle();
        start = 1'b0;
        a = 8'hxx; b = 8'hxx; cin = 1'bx;
    endtask

    // Edges until done is seen (bounded), and busy samples seen before it.
    task automatic wait_done(output int n, output int nb);
        n = 0; nb = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) nb++;
            step_cycle();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) step_cycle();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (sum !== 8'h00) begin fails++; $display("FAIL reset_sum: got %h want 00", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b want 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst_n = 1'b1;
        step_cycle();
    endtask

    task automatic test_zero();
        int n, nb;
        pulse_start(8'h00, 8'h00, 1'b0);
        wait_done(n, nb);
        tests++; if (n !== 8) begin fails++; $display("FAIL zero_latency: got %0d want 8", n); end
        tests++; if (nb !== 8) begin fails++; $display("FAIL zero_busy_cycles: got %0d want 8", nb); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy_in_done: got %b want 0", busy); end
        tests++; if (sum !== 8'h00) begin fails++; $display("FAIL zero_sum: got %h want 00", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL zero_cout: got %b want 0", cout); end
        step_cycle();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_width: got %b want 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_carry_out();
        int n, nb;
        pulse_start(8'hFF, 8'h01, 1'b0);
        wait_done(n, nb);
        tests++; if (sum !== 8'h00) begin fails++; $display("FAIL ff01_sum: got %h want 00", sum); end
        tests++; if (cout !== 1'b1) begin fails++; $display("FAIL ff01_cout: got %b want 1", cout); end
`ifdef SERIAL_ADDER_OVF_EN
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ff01_ovf: got %b want 0", ovf); end
`endif
        step_cycle();
        tests++; if (sum !== 8'h00 || cout !== 1'b1) begin fails++; $display("FAIL ff01_hold: got %h/%b want 00/1", sum, cout); end
    endtask

    task automatic test_signed_ovf();
        int n, nb;
        pulse_start(8'h7F, 8'h01, 1'b0);
        wait_done(n, nb);
        tests++; if (sum !== 8'h80) begin fails++; $display("FAIL 7f01_sum: got %h want 80", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL 7f01_cout: got %b want 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL 7f01_ovf: got %b want 1", ovf); end
`endif
        step_cycle();
    endtask

    task automatic test_restart_ignored();
        int n, nb, extra_done;
        pulse_start(8'hA5, 8'h5A, 1'b1);
        repeat (3) step_cycle();
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        step_cycle();
        start = 1'b0;
        wait_done(n, nb);
        tests++; if (n !== 4) begin fails++; $display("FAIL repulse_latency: got %0d want 4 more edges", n); end
        tests++; if (sum !== 8'h00) begin fails++; $display("FAIL repulse_sum: got %h want 00", sum); end
        tests++; if (cout !== 1'b1) begin fails++; $display("FAIL repulse_cout: got %b want 1", cout); end
        extra_done = 0;
        repeat (12) begin
            step_cycle();
            if (done === 1'b1) extra_done++;
        end
        tests++; if (extra_done !== 0) begin fails++; $display("FAIL repulse_single_done: got %0d extra dones want 0", extra_done); end
    endtask

    task automatic test_back_to_back();
        int n, m, nb;
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        wait_done(n, nb);
        tests++; if (n !== 9) begin fails++; $display("FAIL b2b_first_latency: got %0d want 9", n); end
        tests++; if (sum !== 8'h10 || cout !== 1'b0) begin fails++; $display("FAIL b2b_first_result: got %h/%b want 10/0", sum, cout); end
        step_cycle();
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_reassert: got %b want 1", busy); end
        m = 1;
        while (done !== 1'b1 && m < 40) begin
            step_cycle();
            m++;
        end
        tests++; if (m !== 9) begin fails++; $display("FAIL b2b_done_spacing: got %0d want 9", m); end
        tests++; if (sum !== 8'h10) begin fails++; $display("FAIL b2b_sum: got %h want 10", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL b2b_cout: got %b want 0", cout); end
        step_cycle();
    endtask

    task automatic test_reset_abort();
        int n, nb, seen;
        pulse_start(8'h33, 8'h44, 1'b0);
        repeat (3) step_cycle();
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
        tests++; if (sum !== 8'h00) begin fails++; $display("FAIL abort_sum: got %h want 00", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL abort_cout: got %b want 0", cout); end
        step_cycle();
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            step_cycle();
            if (done === 1'b1) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_done: got %0d dones want 0", seen); end
        pulse_start(8'h33, 8'h44, 1'b0);
        wait_done(n, nb);
        tests++; if (n !== 8) begin fails++; $display("FAIL abort_rerun_latency: got %0d want 8", n); end
        tests++; if (sum !== 8'h77) begin fails++; $display("FAIL abort_rerun_sum: got %h want 77", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL abort_rerun_cout: got %b want 0", cout); end
        step_cycle();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_carry_out();
        test_signed_ovf();
        test_restart_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
